// File: rtl/cci_mpf_prim_onehot_to_bin_pipe.sv
// Two-stage registered one-hot to binary encoder, N lanes sharing one valid/ready handshake.
// Flags empty and multi-hot inputs per lane and keeps a saturating count of malformed output beats.
module cci_mpf_prim_onehot_to_bin_pipe #(
  parameter int ONEHOT_WIDTH  = 16,
  parameter int BIN_WIDTH     = (ONEHOT_WIDTH > 1) ? $clog2(ONEHOT_WIDTH) : 1,
  parameter int N_CHANNELS    = 1,
  parameter bit PRIORITY_LOW  = 1'b0,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N_CHANNELS*ONEHOT_WIDTH-1:0] in_onehot,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N_CHANNELS*BIN_WIDTH-1:0]    out_bin,
  output logic [N_CHANNELS-1:0]              out_zero,
  output logic [N_CHANNELS-1:0]              out_multi,
  input  logic                               err_clr,
  output logic [ERR_CNT_WIDTH-1:0]           err_count
);

  localparam int VW = N_CHANNELS * ONEHOT_WIDTH;
  localparam int BW = N_CHANNELS * BIN_WIDTH;

  logic          s1_valid;
  logic [VW-1:0] s1_vec;
  logic [N_CHANNELS-1:0] s1_zero;
  logic [N_CHANNELS-1:0] s1_multi;

  logic          s2_valid;
  logic [BW-1:0] s2_bin;
  logic [N_CHANNELS-1:0] s2_zero;
  logic [N_CHANNELS-1:0] s2_multi;

  logic [VW-1:0] s1_vec_d;
  logic [N_CHANNELS-1:0] s1_zero_d;
  logic [N_CHANNELS-1:0] s1_multi_d;
  logic [BW-1:0] s2_bin_d;

  logic adv1;
  logic adv2;
  logic err_inc;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    logic [ONEHOT_WIDTH-1:0] v;
    logic [ONEHOT_WIDTH-1:0] v_dec;
    logic [ONEHOT_WIDTH-1:0] sv;
    logic [BIN_WIDTH-1:0]    bin;

    assign v     = in_onehot[c*ONEHOT_WIDTH +: ONEHOT_WIDTH];
    assign v_dec = v - ONEHOT_WIDTH'(1);

    assign s1_zero_d[c]  = ~|v;
    assign s1_multi_d[c] = |(v & v_dec);
    // Isolating the lowest set bit lets the OR-encoder below act as a priority encoder.
    assign s1_vec_d[c*ONEHOT_WIDTH +: ONEHOT_WIDTH] =
      PRIORITY_LOW ? (v & (~v + ONEHOT_WIDTH'(1))) : v;

    assign sv = s1_vec[c*ONEHOT_WIDTH +: ONEHOT_WIDTH];

    always_comb begin
      bin = '0;
      for (int j = 0; j < BIN_WIDTH; j++) begin
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
          if (((i >> j) & 1) != 0) begin
            bin[j] = bin[j] | sv[i];
          end
        end
      end
    end

    assign s2_bin_d[c*BIN_WIDTH +: BIN_WIDTH] = bin;
  end

  // in_ready depends on out_ready but never on in_valid.
  assign adv2     = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | adv2;
  assign adv1     = in_valid & in_ready;
  assign err_inc  = s2_valid & out_ready & (|(s2_zero | s2_multi));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      err_count <= '0;
    end else begin
      s1_valid <= adv1 | (s1_valid & ~adv2);
      s2_valid <= adv2 | (s2_valid & ~out_ready);
      if (err_clr) begin
        err_count <= '0;
      end else if (err_inc && !(&err_count)) begin
        err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv1) begin
      s1_vec   <= s1_vec_d;
      s1_zero  <= s1_zero_d;
      s1_multi <= s1_multi_d;
    end
    if (adv2) begin
      s2_bin   <= s2_bin_d;
      s2_zero  <= s1_zero;
      s2_multi <= s1_multi;
    end
  end

  assign out_valid = s2_valid;
  assign out_bin   = s2_bin;
  assign out_zero  = s2_zero;
  assign out_multi = s2_multi;

endmodule

// File: tb/tb_cci_mpf_prim_onehot_to_bin_pipe.sv
// Bench for the pipelined one-hot encoder: two instances (OR-encode with 2-bit error counter,
// lowest-index priority with 16-bit counter) driven in lockstep and scored against a beat queue.
module tb_cci_mpf_prim_onehot_to_bin_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_onehot = '0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [7:0]  out_bin0, out_bin1;
  logic [1:0]  out_zero0, out_zero1;
  logic [1:0]  out_multi0, out_multi1;
  logic [1:0]  err_count0;
  logic [15:0] err_count1;

  always #5 clk = ~clk;

  cci_mpf_prim_onehot_to_bin_pipe #(
    .ONEHOT_WIDTH(16), .N_CHANNELS(2), .PRIORITY_LOW(1'b0), .ERR_CNT_WIDTH(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_onehot(in_onehot), .out_valid(out_valid0), .out_ready(out_ready),
    .out_bin(out_bin0), .out_zero(out_zero0), .out_multi(out_multi0),
    .err_clr(err_clr), .err_count(err_count0)
  );

  cci_mpf_prim_onehot_to_bin_pipe #(
    .ONEHOT_WIDTH(16), .N_CHANNELS(2), .PRIORITY_LOW(1'b1), .ERR_CNT_WIDTH(16)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_onehot(in_onehot), .out_valid(out_valid1), .out_ready(out_ready),
    .out_bin(out_bin1), .out_zero(out_zero1), .out_multi(out_multi1),
    .err_clr(err_clr), .err_count(err_count1)
  );

  typedef struct {
    logic [31:0] oh;
    int          acc;
  } beat_t;

  beat_t q[$];
  int    n_assert = 0;
  int    n_fail = 0;
  int    edge_n = 0;
  int    err_m0 = 0;
  int    err_m1 = 0;
  bit    exp_ov = 1'b0;

  function automatic logic [7:0] exp_bin(input logic [31:0] oh, input bit pl);
    logic [7:0] r;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      logic [15:0] v;
      int b;
      v = oh[c*16 +: 16];
      b = 0;
      if (pl) begin
        for (int i = 15; i >= 0; i--) if (v[i]) b = i;
      end else begin
        for (int i = 0; i < 16; i++) if (v[i]) b = b | i;
      end
      r[c*4 +: 4] = b[3:0];
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_zero(input logic [31:0] oh);
    return {oh[31:16] == 16'h0, oh[15:0] == 16'h0};
  endfunction

  function automatic logic [1:0] exp_multi(input logic [31:0] oh);
    return {$countones(oh[31:16]) > 1, $countones(oh[15:0]) > 1};
  endfunction

  function automatic logic [15:0] rand_lane();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'h0;
    if (r == 1) return 16'($urandom);
    return 16'h1 << $urandom_range(0, 15);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid0", out_valid0, exp_ov);
    chk("out_valid1", out_valid1, exp_ov);
    if (exp_ov) begin
      chk("out_bin_or",   out_bin0,   exp_bin(q[0].oh, 1'b0));
      chk("out_bin_pri",  out_bin1,   exp_bin(q[0].oh, 1'b1));
      chk("out_zero0",    out_zero0,  exp_zero(q[0].oh));
      chk("out_zero1",    out_zero1,  exp_zero(q[0].oh));
      chk("out_multi0",   out_multi0, exp_multi(q[0].oh));
      chk("out_multi1",   out_multi1, exp_multi(q[0].oh));
    end
    chk("err_count0", err_count0, err_m0);
    chk("err_count1", err_count1, err_m1);
  endtask

  task automatic step(input bit iv, input logic [31:0] oh, input bit ordy, input bit clr,
                      output bit acc);
    bit    exp_rdy;
    bit    pop;
    beat_t b;
    @(negedge clk);
    in_valid  = iv;
    in_onehot = oh;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    chk("in_ready0", in_ready0, exp_rdy);
    chk("in_ready1", in_ready1, exp_rdy);
    acc = iv && exp_rdy;
    pop = exp_ov && ordy;
    @(posedge clk);
    edge_n++;
    if (pop) begin
      b = q.pop_front();
      if (!clr && ((exp_zero(b.oh) | exp_multi(b.oh)) != 2'b00)) begin
        if (err_m0 < 3) err_m0++;
        if (err_m1 < 65535) err_m1++;
      end
    end
    if (clr) begin
      err_m0 = 0;
      err_m1 = 0;
    end
    if (acc) q.push_back('{oh: oh, acc: edge_n});
    exp_ov = (q.size() > 0) && (edge_n - q[0].acc >= 1);
    #1;
    check_outputs();
  endtask

  initial begin
    bit acc;
    int sent;
    logic [3:0] pat;

    #12;
    chk("rst_in_ready0", in_ready0, 1'b1);
    chk("rst_in_ready1", in_ready1, 1'b1);
    chk("rst_out_valid0", out_valid0, 1'b0);
    chk("rst_out_valid1", out_valid1, 1'b0);
    chk("rst_err0", err_count0, 2'd0);
    chk("rst_err1", err_count1, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Well-formed stream, no back-pressure
    step(1'b1, {16'h8000, 16'h0001}, 1'b1, 1'b0, acc);
    step(1'b1, {16'h0002, 16'h0400}, 1'b1, 1'b0, acc);
    chk("lat_bin_t2", out_bin0, {4'd15, 4'd0});
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("lat_bin_t3", out_bin0, {4'd1, 4'd10});
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Malformed beats, saturation of the narrow counter and clear coincident with an increment
    for (int i = 0; i < 10; i++) begin
      logic [31:0] mal;
      case (i)
        0: mal = {16'h0001, 16'h0000};
        1: mal = {16'h0001, 16'h0006};
        2: mal = {16'h0001, 16'hF000};
        3: mal = {16'h0000, 16'h0003};
        4: mal = {16'hFFFF, 16'h0000};
        default: mal = {16'h0006, 16'h0080};
      endcase
      step(i < 6, mal, 1'b1, i == 7, acc);
    end

    // Back-pressure with repeating out_ready 1-0-0-1
    sent = 0;
    pat = 4'b1001;
    for (int k = 0; k < 40 && sent < 8; k++) begin
      step(1'b1, {16'h8000 >> sent, 16'h0001 << sent}, pat[k % 4], 1'b0, acc);
      if (acc) sent++;
    end
    chk("bp_all_sent", sent, 8);
    for (int k = 0; k < 12; k++) step(1'b0, 32'h0, pat[k % 4], 1'b0, acc);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, {rand_lane(), rand_lane()}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0, acc);
    end

    // Fill both stages and reset asynchronously mid-cycle
    step(1'b1, {16'h0000, 16'h0010}, 1'b0, 1'b0, acc);
    step(1'b1, {16'h0003, 16'h0020}, 1'b0, 1'b0, acc);
    step(1'b1, {16'h0100, 16'h0040}, 1'b0, 1'b0, acc);
    #2;
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid0", out_valid0, 1'b0);
    chk("arst_out_valid1", out_valid1, 1'b0);
    chk("arst_in_ready0", in_ready0, 1'b1);
    chk("arst_in_ready1", in_ready1, 1'b1);
    chk("arst_err0", err_count0, 2'd0);
    chk("arst_err1", err_count1, 16'd0);
    q.delete();
    err_m0 = 0;
    err_m1 = 0;
    exp_ov = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, {16'h0200, 16'h0004}, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("post_rst_bin", out_bin1, {4'd9, 4'd2});
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
